dmem_responder: RTL

Bus responder (slave side) for the data-memory port of the core's memory controller. It accepts transfers on the same 1-bit-HTRANS / HADDR / HWRITE / HWDATA bus driven by the instruction-fetch and memory-access stages. It returns HRDATA with a programmable number of wait states and supports byte, half, word and doubleword writes through lane masking. It is the writable counterpart to the existing read-only ROM responder and sits behind the controller alongside it.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_if.sv | 17 +
 rtl/dmem_bank.sv | 38 +++
 rtl/dmem_responder.sv | 114 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and byte-lane mask helper for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_e;

    // Little-endian byte-write mask for an access of the given size at low address bits lo.
    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] lo);
        logic [7:0] base;
        case (size)
            SIZE_BYTE: base = 8'h01;
            SIZE_HALF: base = 8'h03;
            SIZE_WORD: base = 8'h0F;
            default:   base = 8'hFF;
        endcase
        return base << lo;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory bus between the memory controller (master) and a responder (slave).
interface dmem_if;
    logic        HSEL;
    logic        HTRANS;
    logic [63:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
                    input  HRDATA, HREADY, HRESP);
    modport slave  (input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
                    output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 64 storage: byte-enabled write port, synchronous read port whose
// output register holds between reads and forwards a same-edge write to the same word.
module dmem_bank #(
    parameter int  DEPTH_WORDS = 512,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [7:0]    we,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wdata,
    input  logic          rd_en,
    input  logic          clr,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH_WORDS];
    logic [63:0] fwd;

    // Contents survive reset on purpose.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 8; b++)
            if (we[b]) mem[wr_addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end

    always_comb begin
        fwd = mem[rd_addr];
        if (wr_addr == rd_addr)
            for (int b = 0; b < 8; b++)
                if (we[b]) fwd[b*8 +: 8] = wdata[b*8 +: 8];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)     rdata <= '0;
        else if (clr)   rdata <= '0;
        else if (rd_en) rdata <= fwd;
    end
endmodule

// File: rtl/dmem_responder.sv
// Writable data-memory responder with programmable wait states and single-cycle error response.
// Optional DMEM_MISALIGN_CHECK_EN: misaligned half/word/dword accesses error instead of aligning down.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_WORDS = 512,
    parameter int          WAIT_STATES = 1
) (
    input  logic  CLK,
    input  logic  RESET,
    dmem_if.slave bus
);
    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic [7:0]    be_q;
    logic          wr_q, err_q, hready_q, hresp_q;

    logic          accept, dec_err, misalign, rd_en, clr;
    logic [63:0]   off;
    logic [AW-1:0] idx, rd_addr;
    logic [2:0]    lo;
    logic [7:0]    we;

    assign accept = bus.HSEL & bus.HTRANS & hready_q;
    assign off    = bus.HADDR - BASE_ADDR;
    assign idx    = off[AW+2:3];

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        case (bus.HSIZE)
            SIZE_HALF:  misalign = bus.HADDR[0];
            SIZE_WORD:  misalign = |bus.HADDR[1:0];
            SIZE_DWORD: misalign = |bus.HADDR[2:0];
            default:    misalign = 1'b0;
        endcase
    end
    assign lo = bus.HADDR[2:0];
`else
    assign misalign = 1'b0;
    // Drop address bits below the access size so the lanes align down.
    always_comb begin
        case (bus.HSIZE)
            SIZE_BYTE: lo = bus.HADDR[2:0];
            SIZE_HALF: lo = {bus.HADDR[2:1], 1'b0};
            SIZE_WORD: lo = {bus.HADDR[2], 2'b00};
            default:   lo = 3'b000;
        endcase
    end
`endif

    assign dec_err = (bus.HADDR < BASE_ADDR) || ((off >> 3) >= 64'(DEPTH_WORDS)) ||
                     (bus.HSIZE > SIZE_DWORD) || misalign;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            WAIT:    state_d = (cnt_q == 3'd0) ? DATA : WAIT;
            default: if (accept) state_d = (dec_err || NO_WAIT) ? DATA : WAIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hready_q <= (state_d != WAIT);
            hresp_q  <= accept & dec_err;
            if (accept) begin
                idx_q <= idx;
                wr_q  <= bus.HWRITE;
                err_q <= dec_err;
                be_q  <= lane_mask(bus.HSIZE, lo);
                if (!dec_err && !NO_WAIT) cnt_q <= 3'(WAIT_STATES - 1);
            end else if (state_q == WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    // Reads launch on the edge that enters DATA, so HRDATA only moves on completions.
    assign we      = (state_q == DATA && wr_q && !err_q) ? be_q : 8'h00;
    assign rd_en   = (state_q == WAIT && cnt_q == 3'd0 && !wr_q) ||
                     (accept && !bus.HWRITE && !dec_err && NO_WAIT);
    assign rd_addr = (state_q == WAIT) ? idx_q : idx;
    assign clr     = accept & dec_err;

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .CLK     (CLK),
        .RESET   (RESET),
        .we      (we),
        .wr_addr (idx_q),
        .wdata   (bus.HWDATA),
        .rd_en   (rd_en),
        .clr     (clr),
        .rd_addr (rd_addr),
        .rdata   (bus.HRDATA)
    );

    assign bus.HREADY = hready_q;
    assign bus.HRESP  = hresp_q;
endmodule
